// File: rtl/cpu_pkg.sv
// Constants shared by the multicycle datapath blocks: word width and
// memory-port FSM state encodings.
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] MP_IDLE = 2'b00;
  localparam logic [1:0] MP_WAIT = 2'b01;
  localparam logic [1:0] MP_DONE = 2'b10;

  // Both strobes at once, or a strobe with a misaligned byte address.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [1:0] lsb);
    return (rd && wr) || ((rd || wr) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; contents are never reset.
module mem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_port.sv
// Unified instruction/data memory port with request/ready handshake and
// a fixed number of wait states before each access completes.
//
// state   | meaning
// MP_IDLE | waiting for a legal request; flags illegal ones in Err
// MP_WAIT | counting down wait states
// MP_DONE | access performed at the closing edge, Ready high
module mem_port
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  localparam int         IW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0]        state, nstate;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [IW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              accept, illegal;
  logic [IW-1:0]     ram_idx;
  logic              ram_we, ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^Addr[31:IW+2];

  assign illegal = req_illegal(MemRead, MemWrite, Addr[1:0]);
  assign accept  = (state == MP_IDLE) && (MemRead ^ MemWrite) && (Addr[1:0] == 2'b00);

  always_comb begin
    nstate = state;
    case (state)
      MP_IDLE: if (accept) nstate = (LAT == 4'd0) ? MP_DONE : MP_WAIT;
      MP_WAIT: if (cnt <= 4'd1) nstate = MP_DONE;
      MP_DONE: nstate = MP_IDLE;
      default: nstate = MP_IDLE;
    endcase
  end

  // RAM read is issued on entry to DONE so its data is ready by DONE's closing edge.
  assign ram_idx = (state == MP_IDLE) ? Addr[IW+1:2] : idx_q;
  assign ram_re  = (state != MP_DONE) && (nstate == MP_DONE);
  assign ram_we  = (state == MP_DONE) && op_wr;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MP_IDLE;
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ReadData <= '0;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      state <= nstate;
      Busy  <= (nstate != MP_IDLE);
      Ready <= (nstate == MP_DONE);
      if ((state == MP_IDLE) && illegal) Err <= 1'b1;
      if (accept) begin
        op_wr   <= MemWrite;
        idx_q   <= Addr[IW+1:2];
        wdata_q <= WriteData;
        cnt     <= LAT;
      end else if (state == MP_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == MP_DONE) && !op_wr) ReadData <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: two instances (2 and 0 wait states) checked against a
// word-array reference model with cycle-exact handshake expectations.
module tb_mem_port;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mr [2];
  logic        mw [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rdv [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        er  [2];

  int          lat [2] = '{2, 0};
  logic [31:0] mem_model [2][DEPTH];
  logic [31:0] rd_model [2];
  logic        err_model [2];
  logic [31:0] written [2][$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .Addr(ad[0]),
    .WriteData(wd[0]), .ReadData(rdv[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Err(er[0])
  );

  mem_port #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .Addr(ad[1]),
    .WriteData(wd[1]), .ReadData(rdv[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Err(er[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input int u, input string tag);
    chk({tag, ".busy"},  32'(bsy[u]), 32'd0);
    chk({tag, ".ready"}, 32'(rdy[u]), 32'd0);
    chk({tag, ".rdata"}, rdv[u], rd_model[u]);
    chk({tag, ".err"},   32'(er[u]), 32'(err_model[u]));
  endtask

  // Caller is at a falling edge; request is sampled at the next rising edge.
  task automatic access(input int u, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int w;
    w = int'((a >> 2) % DEPTH);
    mr[u] = !wr; mw[u] = wr; ad[u] = a; wd[u] = d;
    @(posedge clk);
    @(negedge clk);
    mr[u] = 1'b0; mw[u] = 1'b0; ad[u] = $urandom; wd[u] = $urandom;
    for (int c = 0; c <= lat[u]; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("u%0d.busy_c%0d", u, c),  32'(bsy[u]), 32'd1);
      chk($sformatf("u%0d.ready_c%0d", u, c), 32'(rdy[u]), (c == lat[u]) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d.hold_c%0d", u, c),  rdv[u], rd_model[u]);
    end
    @(negedge clk);
    if (wr) mem_model[u][w] = d;
    else    rd_model[u]     = mem_model[u][w];
    if (wr) written[u].push_back(a);
    chk_idle_outputs(u, $sformatf("u%0d.after_%s_%h", u, wr ? "wr" : "rd", a));
  endtask

  task automatic illegal_req(input int u, input bit r, input bit w, input logic [31:0] a);
    mr[u] = r; mw[u] = w; ad[u] = a; wd[u] = $urandom;
    @(posedge clk);
    @(negedge clk);
    mr[u] = 1'b0; mw[u] = 1'b0;
    err_model[u] = 1'b1;
    chk_idle_outputs(u, $sformatf("u%0d.illegal1_%h", u, a));
    @(negedge clk);
    chk_idle_outputs(u, $sformatf("u%0d.illegal2_%h", u, a));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      rd_model[u]  = '0;
      err_model[u] = 1'b0;
      chk_idle_outputs(u, $sformatf("%s.u%0d", tag, u));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    for (int u = 0; u < 2; u++) begin
      mr[u] = 1'b0; mw[u] = 1'b0; ad[u] = '0; wd[u] = '0;
      rd_model[u] = '0; err_model[u] = 1'b0;
    end
    #2;
    for (int u = 0; u < 2; u++) chk_idle_outputs(u, $sformatf("por.u%0d", u));
    @(negedge clk);
    do_reset("reset");

    // Directed: preload, read, write/read, wrap.
    access(0, 1'b1, 32'h14, 32'hDEADBEEF);
    access(0, 1'b0, 32'h14, 32'h0);
    access(0, 1'b1, 32'h20, 32'h0000_00A5);
    access(0, 1'b0, 32'h20, 32'h0);
    access(0, 1'b1, 32'h1000, 32'h1234);
    access(0, 1'b0, 32'h0, 32'h0);

    // Illegal requests, each followed by a reset to clear the sticky flag.
    illegal_req(0, 1'b1, 1'b1, 32'h8);
    do_reset("clr_err1");
    illegal_req(0, 1'b1, 1'b0, 32'h22);
    illegal_req(1, 1'b0, 1'b1, 32'h3);
    do_reset("clr_err2");

    // Reset during a write's wait phase leaves the target word untouched.
    access(0, 1'b1, 32'h40, 32'h5555_AAAA);
    mw[0] = 1'b1; ad[0] = 32'h40; wd[0] = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    mw[0] = 1'b0;
    chk("midwr.busy_before", 32'(bsy[0]), 32'd1);
    do_reset("midwr");
    access(0, 1'b0, 32'h40, 32'h0);
    chk("midwr.oldword", rdv[0], 32'h5555_AAAA);

    // Zero wait states: back-to-back reads complete two cycles apart.
    access(1, 1'b1, 32'h0, 32'hCAFE_0000);
    access(1, 1'b1, 32'h4, 32'hCAFE_0004);
    access(1, 1'b0, 32'h0, 32'h0);
    access(1, 1'b0, 32'h4, 32'h0);
    chk("lat0.data4", rdv[1], 32'hCAFE_0004);

    // Random traffic; reads revisit written words, sometimes via a wrapped alias.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 40; i++) begin
        if (written[u].size() == 0 || $urandom_range(0, 1) == 0) begin
          a = {$urandom_range(0, 32'hFFFF)} & 32'hFFFF_FFFC;
          access(u, 1'b1, a, $urandom);
        end else begin
          a = written[u][$urandom_range(0, written[u].size() - 1)];
          a = a + 32'h1000 * $urandom_range(0, 3);
          access(u, 1'b0, a, 32'h0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port.md
# mem_port

Word-addressed unified instruction/data memory with a request/ready handshake and a programmable wait-state count. It sits directly downstream of the multicycle control state machine and datapath address mux. It consumes MemRead, MemWrite, the IorD-selected address and the B-register write data, and returns ReadData to the instruction register and MDR. Wait states let the same datapath model slower memory; a stall-capable controller holds its memory state until Ready.

## Interface
- DEPTH_WORDS, default 1024: number of 32-bit words; must be a power of two.
- LATENCY, default 2: wait cycles between acceptance and completion; 0..15.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; asynchronous and active-high, as already decided for this block.
- MemRead  input  1  read request.
- MemWrite  input  1  write request.
- Addr  input  32  byte address; word index = Addr[log2(DEPTH_WORDS)+1:2].
- WriteData  input  32  store data.
- ReadData  output  32  last completed read data, held until the next read completes.
- Ready  output  1  one-cycle pulse on the completion cycle of an accepted access.
- Busy  output  1  high from acceptance until completion.
- Err  output  1  sticky error flag, cleared only by rst.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE: if exactly one of MemRead or MemWrite is high and Addr[1:0]==0, latch op, word index and WriteData, load cnt=LATENCY, then go to WAIT. LATENCY=0 goes straight to DONE.
- IDLE, illegal request: MemRead and MemWrite both high, or Addr[1:0]!=0.
  - Set Err and stay in IDLE.
  - No memory access and no Ready pulse.
- WAIT: decrement cnt each cycle. When cnt reaches 1, go to DONE on the next edge.
- DONE: perform the access using the latched values.
  - Read: ReadData <= mem[idx].
  - Write: mem[idx] <= latched WriteData; ReadData unchanged.
  - Ready=1 for this one cycle. Next state is IDLE.
- Inputs are ignored while Busy. A new request is sampled only in IDLE, so the earliest next acceptance is the cycle after DONE.
- Address bits above the index are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Memory contents are not affected by rst. Simulation preloads them via $readmemb in the testbench hierarchy.

## Timing
- Reset values: ReadData=0, Ready=0, Busy=0, Err=0, FSM=IDLE, cnt=0.
- Busy is registered. It rises the cycle after acceptance and falls after DONE.
  - In WAIT and DONE: Busy=1.
  - In IDLE: Busy=0.
- Latency: request sampled at edge k; Ready high during cycle k+LATENCY+1; ReadData valid from edge k+LATENCY+1 onward.
- Ready and ReadData are registered outputs; no combinational path from inputs to outputs.
- rst mid-operation aborts immediately: a pending write is not performed and ReadData returns to 0.
- A request held high across DONE is re-accepted in the following IDLE cycle. The requester must drop the request on Ready to avoid repeats.

## Structure
- Shared package (cpu_pkg):
  - state encoding constants MP_IDLE=2'b00, MP_WAIT=2'b01, MP_DONE=2'b10;
  - WORD_W=32.
- Sub-module mem_array: a single-port synchronous RAM (clk, we, re, idx, wdata, rdata) holding the storage. mem_port owns the FSM, counter, latches and Err.

## Test plan
- LATENCY=2, mem[5]=32'hDEADBEEF; MemRead=1, Addr=32'h14 for one cycle → Busy on the next 3 cycles, Ready pulse 3 cycles after sampling, ReadData=32'hDEADBEEF held afterwards.
- Write then read: MemWrite with Addr=32'h20, WriteData=32'h0000_00A5, then MemRead at the same address → ReadData=32'h0000_00A5. ReadData is unchanged during the write.
- Illegal requests:
  - MemRead=MemWrite=1 → Err=1, no Ready, Busy stays 0;
  - separately, Addr=32'h22 → Err=1.
- Wrap: DEPTH_WORDS=1024, write 32'h1234 at Addr=32'h1000 → a read at Addr=0 returns 32'h1234.
- Reset mid-write: assert rst while in WAIT → all outputs return to reset values and the target word keeps its old value.
- LATENCY=0: back-to-back reads at 0x0 and 0x4, each held one cycle → Ready pulses on consecutive completion cycles 2 cycles apart, with correct data.
